// File: rtl/rv32_mul_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_mul_div_unit_if                                         |
// | Description : Execute-stage <-> RV32M mul/div engine request/response      |
// |               bundle. The pipeline side is the master; the engine is the   |
// |               slave.                                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rv32_mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            abort_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_val_i;
  logic [XLEN-1:0] rs2_val_i;
  logic [4:0]      rd_i;
  logic            running_o;
  logic            done_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, abort_i, funct3_i, rs1_val_i, rs2_val_i, rd_i,
    input  running_o, done_o, rd_o, result_o
  );

  modport slave (
    input  start_i, abort_i, funct3_i, rs1_val_i, rs2_val_i, rd_i,
    output running_o, done_o, rd_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/rv32_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_mul_div_unit                                            |
// | Description : Iterative RV32M multiply/divide engine. Shift-add multiply   |
// |               and restoring divide, one bit per clock, on magnitudes with  |
// |               a sign fix-up at the end. Divide-by-zero and signed overflow |
// |               finish in one cycle with a preloaded result.                 |
// |               Optional: define RV32_FAST_MUL_EN for single-cycle multiply. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32_mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  rv32_mul_div_unit_if.slave bus
);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [XLEN-1:0]  C_ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  C_ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  C_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_LAST_ITR = CNT_W'(XLEN-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              running;
  logic              done;

  // ---------------------------------------------------------------------------
  // Start-cycle operand decode
  // ---------------------------------------------------------------------------
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_neg_start;
  logic            w_b_zero, w_ovf;

  assign w_a_signed = (bus.funct3_i == F3_MULH) || (bus.funct3_i == F3_MULHSU) ||
                      (bus.funct3_i == F3_DIV)  || (bus.funct3_i == F3_REM);
  assign w_b_signed = (bus.funct3_i == F3_MULH) || (bus.funct3_i == F3_DIV) ||
                      (bus.funct3_i == F3_REM);
  assign w_sa       = w_a_signed & bus.rs1_val_i[XLEN-1];
  assign w_sb       = w_b_signed & bus.rs2_val_i[XLEN-1];
  assign w_abs_a    = w_sa ? (~bus.rs1_val_i + 1'b1) : bus.rs1_val_i;
  assign w_abs_b    = w_sb ? (~bus.rs2_val_i + 1'b1) : bus.rs2_val_i;
  assign w_b_zero   = (bus.rs2_val_i == C_ZERO);
  // Signed overflow (MIN / -1) only applies to the signed divide opcodes.
  assign w_ovf      = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
                      (bus.rs1_val_i == C_MIN) && (bus.rs2_val_i == C_ONES);

  // Result sign: quotient/product take sA^sB, remainder takes the dividend sign.
  // MUL keeps only the low word, which is identical for signed and unsigned.
  always_comb begin
    w_neg_start = 1'b0;
    case (bus.funct3_i)
      F3_MULH, F3_MULHSU, F3_DIV: w_neg_start = w_sa ^ w_sb;
      F3_REM:                     w_neg_start = w_sa;
      default:                    w_neg_start = 1'b0;
    endcase
  end

`ifdef RV32_FAST_MUL_EN
  // Sign-extended operands: a 33x33 signed product that fits in 64 bits.
  logic signed [2*XLEN-1:0] w_fast_a, w_fast_b;
  logic        [2*XLEN-1:0] w_fast_prod;
  assign w_fast_a    = {{XLEN{w_a_signed & bus.rs1_val_i[XLEN-1]}}, bus.rs1_val_i};
  assign w_fast_b    = {{XLEN{w_b_signed & bus.rs2_val_i[XLEN-1]}}, bus.rs2_val_i};
  assign w_fast_prod = w_fast_a * w_fast_b;
`endif

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Multiply: acc = {partial product high, remaining multiplier bits}.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_next;
  assign w_rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, b_q});
  assign w_rem_sub  = w_rem_sh[XLEN-1:0] - b_q;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], w_ge};

  // ---------------------------------------------------------------------------
  // Result selection and sign fix-up
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_mul_full;
  logic [XLEN-1:0]   w_div_val, w_div_res;
  logic [XLEN-1:0]   w_result;

  // The product must be negated as a whole 64-bit value before taking the high half.
  assign w_mul_full = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign w_div_val  = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign w_div_res  = neg_q ? (~w_div_val + 1'b1) : w_div_val;

  // Pick low word, high word or divide result by the latched opcode.
  always_comb begin
    w_result = C_ZERO;
    case (funct3_q)
      F3_MUL:                        w_result = w_mul_full[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  w_result = w_mul_full[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU, F3_REM, F3_REMU: w_result = w_div_res;
      default:                       w_result = C_ZERO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    running  = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          running  = 1'b1;
          funct3_d = bus.funct3_i;
          rd_d     = bus.rd_i;
          cnt_d    = '0;
          if (bus.funct3_i[2]) begin
            if (w_b_zero) begin
              // Quotient all-ones, remainder = dividend, no sign fix-up.
              state_d = S_DONE;
              neg_d   = 1'b0;
              acc_d   = bus.funct3_i[1] ? {bus.rs1_val_i, C_ZERO} : {C_ZERO, C_ONES};
            end else if (w_ovf) begin
              state_d = S_DONE;
              neg_d   = 1'b0;
              acc_d   = bus.funct3_i[1] ? {C_ZERO, C_ZERO} : {C_ZERO, C_MIN};
            end else begin
              state_d = S_CALC;
              neg_d   = w_neg_start;
              b_d     = w_abs_b;
              acc_d   = {C_ZERO, w_abs_a};
            end
          end else begin
`ifdef RV32_FAST_MUL_EN
            state_d = S_DONE;
            neg_d   = 1'b0;
            acc_d   = w_fast_prod;
`else
            state_d = S_CALC;
            neg_d   = w_neg_start;
            b_d     = w_abs_b;
            acc_d   = {C_ZERO, w_abs_a};
`endif
          end
        end
      end

      S_CALC: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          running = 1'b1;
          acc_d   = funct3_q[2] ? w_div_next : w_mul_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == C_LAST_ITR) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = !bus.abort_i;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      b_q      <= C_ZERO;
      acc_q    <= {C_ZERO, C_ZERO};
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.running_o = running;
  assign bus.done_o    = done;
  assign bus.rd_o      = rd_q;
  // Result is only presented alongside the done strobe.
  assign bus.result_o  = done ? w_result : C_ZERO;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rv32_mul_div_unit                                         |
// | Description : Directed self-checking bench for rv32_mul_div_unit.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rv32_mul_div_unit;

  logic clk_i;
  logic rst_n_i;
  int   n_checks;
  int   n_fail;

  rv32_mul_div_unit_if #(.XLEN(32)) mdif ();

  rv32_mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (mdif.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

`ifdef RV32_FAST_MUL_EN
  localparam int MUL_RUN = 1;
`else
  localparam int MUL_RUN = 33;
`endif

  // Drive one op from a falling edge; collect busy cycles and the done response.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int run_cycles,
                        output logic [31:0] res, output logic [4:0] rdo, output bit got_done);
    run_cycles = 0;
    got_done   = 1'b0;
    res        = '0;
    rdo        = '0;
    @(negedge clk_i);
    mdif.start_i   = 1'b1;
    mdif.funct3_i  = f3;
    mdif.rs1_val_i = a;
    mdif.rs2_val_i = b;
    mdif.rd_i      = rd;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (mdif.running_o) run_cycles++;
      if (mdif.done_o) begin
        got_done = 1'b1;
        res      = mdif.result_o;
        rdo      = mdif.rd_o;
        break;
      end
      @(posedge clk_i);
      #1 mdif.start_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset;
    mdif.start_i   = 1'b0;
    mdif.abort_i   = 1'b0;
    mdif.funct3_i  = 3'd0;
    mdif.rs1_val_i = '0;
    mdif.rs2_val_i = '0;
    mdif.rd_i      = '0;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({mdif.running_o, mdif.done_o, mdif.rd_o, mdif.result_o} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got run=%0b done=%0b rd=%0d res=%h, want all zero",
               mdif.running_o, mdif.done_o, mdif.rd_o, mdif.result_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_mul;
    int rc; logic [31:0] r; logic [4:0] rdo; bit d;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, rc, r, rdo, d);
    n_checks++;
    if (rc !== MUL_RUN) begin
      n_fail++; $display("FAIL mul_running_cycles: got %0d want %0d", rc, MUL_RUN);
    end
    n_checks++;
    if (!d || r !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_result: done=%0b got %h want ffffffeb", d, r);
    end
    n_checks++;
    if (rdo !== 5'd11) begin
      n_fail++; $display("FAIL mul_rd: got %0d want 11", rdo);
    end
    @(negedge clk_i);
    n_checks++;
    if (mdif.done_o !== 1'b0 || mdif.running_o !== 1'b0) begin
      n_fail++; $display("FAIL mul_done_one_cycle: done=%0b run=%0b want 0 0",
                         mdif.done_o, mdif.running_o);
    end
  endtask

  task automatic test_mulh_variants;
    int rc; logic [31:0] r; logic [4:0] rdo; bit d;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mulhu_result: got %h want fffffffe", r);
    end
    @(negedge clk_i);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'h0000_0000) begin
      n_fail++; $display("FAIL mulh_result: got %h want 00000000", r);
    end
    @(negedge clk_i);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mulhsu_result: got %h want ffffffff", r);
    end
    n_checks++;
    if (rc !== MUL_RUN) begin
      n_fail++; $display("FAIL mulhsu_running_cycles: got %0d want %0d", rc, MUL_RUN);
    end
    @(negedge clk_i);
  endtask

  task automatic test_div_special;
    int rc; logic [31:0] r; logic [4:0] rdo; bit d;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'h8000_0000 || rc !== 1) begin
      n_fail++; $display("FAIL div_overflow: got %h cyc=%0d want 80000000 cyc=1", r, rc);
    end
    @(negedge clk_i);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'h0 || rc !== 1) begin
      n_fail++; $display("FAIL rem_overflow: got %h cyc=%0d want 00000000 cyc=1", r, rc);
    end
    @(negedge clk_i);
    run_op(3'd5, 32'h1234, 32'h0, 5'd8, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'hFFFF_FFFF || rc !== 1) begin
      n_fail++; $display("FAIL divu_by_zero: got %h cyc=%0d want ffffffff cyc=1", r, rc);
    end
    @(negedge clk_i);
    run_op(3'd7, 32'h1234, 32'h0, 5'd9, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'h1234 || rc !== 1) begin
      n_fail++; $display("FAIL remu_by_zero: got %h cyc=%0d want 00001234 cyc=1", r, rc);
    end
    @(negedge clk_i);
  endtask

  task automatic test_div_normal;
    int rc; logic [31:0] r; logic [4:0] rdo; bit d;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'hFFFF_FFFD || rc !== 33) begin
      n_fail++; $display("FAIL div_neg: got %h cyc=%0d want fffffffd cyc=33", r, rc);
    end
    @(negedge clk_i);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL rem_neg: got %h want ffffffff", r);
    end
    @(negedge clk_i);
    run_op(3'd5, 32'd100, 32'd7, 5'd14, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'd14) begin
      n_fail++; $display("FAIL divu_100_7: got %h want 0000000e", r);
    end
    @(negedge clk_i);
    run_op(3'd7, 32'd100, 32'd7, 5'd0, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'd2 || rdo !== 5'd0) begin
      n_fail++; $display("FAIL remu_100_7_x0: done=%0b got %h rd=%0d want 00000002 rd=0", d, r, rdo);
    end
    @(negedge clk_i);
  endtask

  task automatic test_abort_idle;
    @(negedge clk_i);
    mdif.start_i  = 1'b1;
    mdif.abort_i  = 1'b1;
    mdif.funct3_i = 3'd5;
    mdif.rs1_val_i = 32'd100;
    mdif.rs2_val_i = 32'd7;
    #1;
    n_checks++;
    if (mdif.running_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_running: got %0b want 0", mdif.running_o);
    end
    @(posedge clk_i);
    #1 mdif.start_i = 1'b0;
    mdif.abort_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mdif.running_o !== 1'b0 || mdif.done_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_no_start: run=%0b done=%0b want 0 0",
                         mdif.running_o, mdif.done_o);
    end
  endtask

  task automatic test_abort_calc;
    bit saw_done;
    @(negedge clk_i);
    mdif.start_i   = 1'b1;
    mdif.funct3_i  = 3'd5;
    mdif.rs1_val_i = 32'd1000;
    mdif.rs2_val_i = 32'd3;
    mdif.rd_i      = 5'd15;
    @(posedge clk_i);
    #1 mdif.start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    mdif.abort_i = 1'b1;
    #1;
    n_checks++;
    if (mdif.running_o !== 1'b0 || mdif.done_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_calc_cycle: run=%0b done=%0b want 0 0",
                         mdif.running_o, mdif.done_o);
    end
    @(posedge clk_i);
    #1 mdif.abort_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (mdif.done_o || mdif.running_o) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_calc_idle_after: got activity=1 want 0");
    end
  endtask

  task automatic test_reset_mid_op;
    int rc; logic [31:0] r; logic [4:0] rdo; bit d;
    @(negedge clk_i);
    mdif.start_i   = 1'b1;
    mdif.funct3_i  = 3'd0;
    mdif.rs1_val_i = 32'd5;
    mdif.rs2_val_i = 32'd9;
    mdif.rd_i      = 5'd21;
    @(posedge clk_i);
    #1 mdif.start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({mdif.running_o, mdif.done_o, mdif.rd_o, mdif.result_o} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got run=%0b done=%0b rd=%0d res=%h, want all zero",
               mdif.running_o, mdif.done_o, mdif.rd_o, mdif.result_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 5'd2, rc, r, rdo, d);
    n_checks++;
    if (!d || r !== 32'd14 || rdo !== 5'd2) begin
      n_fail++; $display("FAIL after_reset_divu: got %h rd=%0d want 0000000e rd=2", r, rdo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mul();
    test_mulh_variants();
    test_div_special();
    test_div_normal();
    test_abort_idle();
    test_abort_calc();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
